leaf_stream_packetizer: RTL

//  Transmit half of a leaf's BFT attachment. Takes 32-bit words from a user kernel's ap_vld/ap_ack

---
 rtl/leaf_stream_packetizer_if.sv | 35 +++
 rtl/leaf_stream_packetizer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/leaf_stream_packetizer_if.sv
// Handshake and packet bundle between a user kernel, the BFT switch and the leaf packetizer.
// The master side is the packetizer itself; the slave side is its environment.
interface leaf_stream_packetizer_if #(
  parameter int PAYLOAD_BITS = 32,
  parameter int PACKET_BITS  = 49,
  parameter int CREDIT_BITS  = 8
);
  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic                    vld_user2interface;
  logic                    ack_interface2user;
  logic [PACKET_BITS-1:0]  din_leaf_bft2interface;
  logic [PACKET_BITS-1:0]  dout_leaf_interface2bft;
  logic                    tx_grant;
  logic [CREDIT_BITS-1:0]  credit_count;

  modport master (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    output ack_interface2user,
    input  din_leaf_bft2interface,
    output dout_leaf_interface2bft,
    input  tx_grant,
    output credit_count
  );

  modport slave (
    output din_leaf_user2interface,
    output vld_user2interface,
    input  ack_interface2user,
    output din_leaf_bft2interface,
    input  dout_leaf_interface2bft,
    output tx_grant,
    input  credit_count
  );
endinterface

// File: rtl/leaf_stream_packetizer.sv
// Transmit half of a leaf BFT attachment: wraps user words into credit-gated packets addressed
// to a fixed (leaf, port) with a rolling BRAM write address; credits come back as update packets.
module leaf_stream_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int DEST_LEAF             = 0,
  parameter int DEST_PORT             = 1,
  parameter int SRC_PORT              = 1
) (
  input logic                      clk_bft,
  input logic                      reset,
  leaf_stream_packetizer_if.master bus
);

  localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
  localparam int ADDR_LSB    = PAYLOAD_BITS;
  localparam int PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;
  localparam int VLD_BIT     = LEAF_LSB + NUM_LEAF_BITS;

  localparam logic [CREDIT_BITS:0]     CREDIT_MAX = (CREDIT_BITS+1)'(2**NUM_BRAM_ADDR_BITS);
  localparam logic [CREDIT_BITS:0]     CREDIT_INC = (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE);
  localparam logic [NUM_LEAF_BITS-1:0] LEAF_ID    = NUM_LEAF_BITS'(DEST_LEAF);
  localparam logic [NUM_PORT_BITS-1:0] PORT_ID    = NUM_PORT_BITS'(DEST_PORT);
  localparam logic [NUM_PORT_BITS-1:0] SRC_ID     = NUM_PORT_BITS'(SRC_PORT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_CREDIT,
    S_SEND
  } state_t;

  state_t                   state_q, state_d;
  logic [PAYLOAD_BITS-1:0]  word_q;
  logic [NUM_ADDR_BITS-1:0] wr_addr_q;
  logic [CREDIT_BITS-1:0]   credit_q, credit_d;
  logic [CREDIT_BITS:0]     credit_sum;
  logic                     ack_q, ack_d;
  logic                     capture;
  logic                     grant_fire;
  logic                     update_hit;
  logic                     unused_din_bits;

  // A freespace update is a valid control packet (port 0) naming our source port in its payload.
  assign update_hit = bus.din_leaf_bft2interface[VLD_BIT]
                   && (bus.din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == '0)
                   && (bus.din_leaf_bft2interface[NUM_PORT_BITS-1:0] == SRC_ID);

  assign unused_din_bits = ^{bus.din_leaf_bft2interface[VLD_BIT-1:LEAF_LSB],
                             bus.din_leaf_bft2interface[PORT_LSB-1:NUM_PORT_BITS]};

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d    = state_q;
    ack_d      = 1'b0;
    capture    = 1'b0;
    grant_fire = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.vld_user2interface) begin
          capture = 1'b1;
          ack_d   = 1'b1;
          state_d = (credit_q != '0) ? S_SEND : S_WAIT_CREDIT;
        end
      end
      S_WAIT_CREDIT: begin
        if (credit_q != '0) state_d = S_SEND;
      end
      S_SEND: begin
        if (bus.tx_grant) begin
          grant_fire = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant and update may land together; apply both, then clamp to the BRAM depth.
  always_comb begin
    credit_sum = {1'b0, credit_q};
    if (update_hit) credit_sum = credit_sum + CREDIT_INC;
    if (grant_fire) credit_sum = credit_sum - 1'b1;
    credit_d = (credit_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_BITS-1:0]
                                         : credit_sum[CREDIT_BITS-1:0];
  end

  always_ff @(posedge clk_bft) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      wr_addr_q <= '0;
      credit_q  <= CREDIT_MAX[CREDIT_BITS-1:0];
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      credit_q <= credit_d;
      if (grant_fire) wr_addr_q <= wr_addr_q + 1'b1;
    end
  end

  // NOTE: the held word is pure datapath; it is only observed in SEND, so it needs no reset.
  always_ff @(posedge clk_bft) begin
    if (capture) word_q <= bus.din_leaf_user2interface;
  end

  always_comb begin
    bus.dout_leaf_interface2bft = '0;
    if (state_q == S_SEND) begin
      bus.dout_leaf_interface2bft = {1'b1, LEAF_ID, PORT_ID, wr_addr_q, word_q};
    end
  end

  assign bus.ack_interface2user = ack_q;
  assign bus.credit_count       = credit_q;

endmodule
